cypher_transmitter: RTL and testbench

Frame generator for the nibble link consumed by `cypher_detector`. On each accepted request it emits the 16-bit cypher as four nibbles, then one 8-bit payload byte as two nibbles, most significant nibble first, each qualified by a one-cycle `write` strobe. `write` drives the detector's `read` and `nibble_out` drives its nibble input. The block sits on the transmit side of the same link, and its payload is the byte the detector presents on its output after a match.

---
 rtl/cypher_transmitter.sv | 125 ++++++++++++
 tb/tb_cypher_transmitter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cypher_transmitter.sv
// rtl/cypher_transmitter.sv - nibble-link frame generator (16-bit cypher + 8-bit payload)
//
// Purpose: on an accepted request, serialises {cypher, data_in} as six nibbles,
// most significant first, each with a one-cycle write strobe. After the last
// nibble, the block can insert an optional idle gap before it accepts the next request.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous, active-high
//   cypher      in   16-bit cypher word, sampled at accept
//   data_in     in   8-bit payload, sampled at accept
//   send        in   request; accepted when send=1 and ready=1
//   hold        in   stall; freezes nibble emission while high
//   ready       out  a new request can be accepted
//   busy        out  frame or gap in progress (complement of ready)
//   nibble_out  out  current nibble, valid while write=1
//   write       out  one-cycle strobe per emitted nibble
//   done        out  pulse coinciding with the last payload nibble
module cypher_transmitter #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cypher,
    input  logic [7:0]  data_in,
    input  logic        send,
    input  logic        hold,
    output logic        ready,
    output logic        busy,
    output logic [3:0]  nibble_out,
    output logic        write,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

    state_t      state;
    logic [23:0] frame;    // shifted left as nibbles go out; top nibble is next
    logic [2:0]  ptr;      // index of the next nibble to emit (0..5)
    logic [3:0]  gap_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            frame      <= '0;
            ptr        <= '0;
            gap_cnt    <= '0;
            nibble_out <= '0;
            write      <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    done  <= 1'b0;
                    if (send && ready) begin
                        frame <= {cypher, data_in};
                        ptr   <= '0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        state <= TX;
                    end
                end

                TX: begin
                    if (hold) begin
                        write <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        write      <= 1'b1;
                        nibble_out <= frame[23:20];
                        frame      <= {frame[19:0], 4'h0};
                        if (ptr == 3'd5) begin
                            done <= 1'b1;
                            ptr  <= '0;
                            if (GAP_CYCLES == 0) begin
                                // ready returns alongside the last nibble
                                ready <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                gap_cnt <= GAP_INIT;
                                state   <= GAP;
                            end
                        end else begin
                            done <= 1'b0;
                            ptr  <= ptr + 3'd1;
                        end
                    end
                end

                GAP: begin
                    // hold deliberately has no effect here
                    write <= 1'b0;
                    done  <= 1'b0;
                    if (gap_cnt == 4'd1) begin
                        gap_cnt <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    write <= 1'b0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cypher_transmitter.sv
// tb/tb_cypher_transmitter.sv - directed bench for cypher_transmitter (gap 0 and gap 3 instances)
module tb_cypher_transmitter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cypher;
    logic [7:0]  data_in;
    logic        hold;
    logic        send_a, send_b;

    logic        ready_a, busy_a, write_a, done_a;
    logic [3:0]  nib_a;
    logic        ready_b, busy_b, write_b, done_b;
    logic [3:0]  nib_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cypher_transmitter #(.GAP_CYCLES(0)) dut_a (
        .clock(clock), .reset(reset), .cypher(cypher), .data_in(data_in),
        .send(send_a), .hold(hold), .ready(ready_a), .busy(busy_a),
        .nibble_out(nib_a), .write(write_a), .done(done_a)
    );

    cypher_transmitter #(.GAP_CYCLES(3)) dut_b (
        .clock(clock), .reset(reset), .cypher(cypher), .data_in(data_in),
        .send(send_b), .hold(1'b0), .ready(ready_b), .busy(busy_b),
        .nibble_out(nib_b), .write(write_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic a_nib(input string tag, input logic [3:0] n, input logic d);
        tick();
        check({tag, "_write"}, {7'd0, write_a}, 8'd1);
        check({tag, "_nib"},   {4'd0, nib_a},   {4'd0, n});
        check({tag, "_done"},  {7'd0, done_a},  {7'd0, d});
    endtask

    task automatic a_idle(input string tag, input logic rdy);
        tick();
        check({tag, "_write"}, {7'd0, write_a}, 8'd0);
        check({tag, "_done"},  {7'd0, done_a},  8'd0);
        check({tag, "_ready"}, {7'd0, ready_a}, {7'd0, rdy});
        check({tag, "_busy"},  {7'd0, busy_a},  {7'd0, ~rdy});
    endtask

    task automatic b_nib(input string tag, input logic [3:0] n, input logic d);
        tick();
        check({tag, "_write"}, {7'd0, write_b}, 8'd1);
        check({tag, "_nib"},   {4'd0, nib_b},   {4'd0, n});
        check({tag, "_done"},  {7'd0, done_b},  {7'd0, d});
        check({tag, "_ready"}, {7'd0, ready_b}, 8'd0);
    endtask

    task automatic b_idle(input string tag, input logic rdy);
        tick();
        check({tag, "_write"}, {7'd0, write_b}, 8'd0);
        check({tag, "_done"},  {7'd0, done_b},  8'd0);
        check({tag, "_ready"}, {7'd0, ready_b}, {7'd0, rdy});
        check({tag, "_busy"},  {7'd0, busy_b},  {7'd0, ~rdy});
    endtask

    initial begin
        reset   = 1'b1;
        send_a  = 1'b0;
        send_b  = 1'b0;
        hold    = 1'b0;
        cypher  = 16'h0000;
        data_in = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_ready_a", {7'd0, ready_a}, 8'd1);
        check("rst_busy_a",  {7'd0, busy_a},  8'd0);
        check("rst_write_a", {7'd0, write_a}, 8'd0);
        check("rst_done_a",  {7'd0, done_a},  8'd0);
        check("rst_nib_a",   {4'd0, nib_a},   8'd0);
        check("rst_ready_b", {7'd0, ready_b}, 8'd1);
        check("rst_busy_b",  {7'd0, busy_b},  8'd0);
        reset = 1'b0;

        // Basic frame; inputs scrambled after accept must not matter
        cypher = 16'h2601; data_in = 8'hA5; send_a = 1'b1;
        tick();
        send_a = 1'b0; cypher = 16'hFFFF; data_in = 8'h00;
        check("acc_ready", {7'd0, ready_a}, 8'd0);
        check("acc_busy",  {7'd0, busy_a},  8'd1);
        check("acc_write", {7'd0, write_a}, 8'd0);
        a_nib("b0", 4'h2, 1'b0);
        a_nib("b1", 4'h6, 1'b0);
        a_nib("b2", 4'h0, 1'b0);
        a_nib("b3", 4'h1, 1'b0);
        a_nib("b4", 4'hA, 1'b0);
        a_nib("b5", 4'h5, 1'b1);
        check("b5_ready", {7'd0, ready_a}, 8'd1);
        check("b5_busy",  {7'd0, busy_a},  8'd0);
        a_idle("b_after", 1'b1);

        // Hold for two edges after the second nibble
        cypher = 16'h2601; data_in = 8'hA5; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        a_nib("h0", 4'h2, 1'b0);
        a_nib("h1", 4'h6, 1'b0);
        hold = 1'b1;
        a_idle("h_stall0", 1'b0);
        a_idle("h_stall1", 1'b0);
        hold = 1'b0;
        a_nib("h2", 4'h0, 1'b0);
        a_nib("h3", 4'h1, 1'b0);
        a_nib("h4", 4'hA, 1'b0);
        a_nib("h5", 4'h5, 1'b1);
        check("h5_ready", {7'd0, ready_a}, 8'd1);
        a_idle("h_after", 1'b1);

        // Request while busy is ignored
        cypher = 16'h2601; data_in = 8'h3C; send_a = 1'b1;
        tick();
        data_in = 8'hFF; cypher = 16'h0000;
        a_nib("i0", 4'h2, 1'b0);
        a_nib("i1", 4'h6, 1'b0);
        send_a = 1'b0;
        a_nib("i2", 4'h0, 1'b0);
        a_nib("i3", 4'h1, 1'b0);
        a_nib("i4", 4'h3, 1'b0);
        a_nib("i5", 4'hC, 1'b1);
        a_idle("i_none0", 1'b1);
        a_idle("i_none1", 1'b1);
        a_idle("i_none2", 1'b1);

        // Reset after the third nibble, then a fresh frame
        cypher = 16'h2601; data_in = 8'hA5; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        a_nib("r0", 4'h2, 1'b0);
        a_nib("r1", 4'h6, 1'b0);
        a_nib("r2", 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        check("r_write", {7'd0, write_a}, 8'd0);
        check("r_ready", {7'd0, ready_a}, 8'd1);
        check("r_busy",  {7'd0, busy_a},  8'd0);
        check("r_done",  {7'd0, done_a},  8'd0);
        reset = 1'b0;
        a_idle("r_quiet", 1'b1);
        cypher = 16'h1234; data_in = 8'h5A; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        a_nib("f0", 4'h1, 1'b0);
        a_nib("f1", 4'h2, 1'b0);
        a_nib("f2", 4'h3, 1'b0);
        a_nib("f3", 4'h4, 1'b0);
        a_nib("f4", 4'h5, 1'b0);
        a_nib("f5", 4'hA, 1'b1);
        a_idle("f_after", 1'b1);

        // Gap of 3 with send held high for back-to-back frames
        cypher = 16'h2601; data_in = 8'h3C; send_b = 1'b1;
        tick();
        data_in = 8'h7E;
        check("g_acc_ready", {7'd0, ready_b}, 8'd0);
        check("g_acc_write", {7'd0, write_b}, 8'd0);
        b_nib("g0", 4'h2, 1'b0);
        b_nib("g1", 4'h6, 1'b0);
        b_nib("g2", 4'h0, 1'b0);
        b_nib("g3", 4'h1, 1'b0);
        b_nib("g4", 4'h3, 1'b0);
        b_nib("g5", 4'hC, 1'b1);
        check("g5_busy", {7'd0, busy_b}, 8'd1);
        b_idle("g_gap0", 1'b0);
        b_idle("g_gap1", 1'b0);
        b_idle("g_gap2", 1'b1);
        b_idle("g_acc2", 1'b0);
        send_b = 1'b0;
        b_nib("k0", 4'h2, 1'b0);
        b_nib("k1", 4'h6, 1'b0);
        b_nib("k2", 4'h0, 1'b0);
        b_nib("k3", 4'h1, 1'b0);
        b_nib("k4", 4'h7, 1'b0);
        b_nib("k5", 4'hE, 1'b1);
        b_idle("k_gap0", 1'b0);
        b_idle("k_gap1", 1'b0);
        b_idle("k_gap2", 1'b1);
        b_idle("k_after", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
